usbeps_tx_burst_player: RTL and testbench

//  Downstream stage of the USB TX deframer. Pops burst descriptors (word count, sample count, timestamp, no-TS flag),

---
 rtl/usbeps_tx_burst_player.sv | 154 +++++++++++++++
 tb/tb_usbeps_tx_burst_player.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usbeps_tx_burst_player.sv
// TX burst player: waits for each descriptor's timestamp, streams its words from TX RAM, skips late bursts.
// Output valid 1 cycle after entering PLAY; a 2-entry skid absorbs RAM latency so ready can stall freely.
module usbeps_tx_burst_player #(
  parameter int DATA_BITS         = 3,
  parameter int TX_TIMESTAMP_BITS = 49,
  parameter int TX_RAM_ADDR_WIDTH = 17,
  parameter int TX_SAMPLES_WIDTH  = 16,
  parameter int RAM_CHECK_BIT     = 8
) (
  input  logic                                                              clk,
  input  logic                                                              rst_n,
  input  logic [TX_TIMESTAMP_BITS+TX_SAMPLES_WIDTH+TX_RAM_ADDR_WIDTH-DATA_BITS-1:0] s_descr_data,
  input  logic                                                              s_descr_valid,
  output logic                                                              s_descr_ready,
  output logic                                                              s_descr_busy,
  output logic                                                              mem_rd_en,
  output logic [TX_RAM_ADDR_WIDTH-DATA_BITS-1:0]                            mem_rd_addr,
  input  logic [(8<<DATA_BITS)-1:0]                                         mem_rd_data,
  output logic                                                              m_axis_tx_valid,
  input  logic                                                              m_axis_tx_ready,
  output logic [(8<<DATA_BITS)-1:0]                                         m_axis_tx_data,
  output logic                                                              m_axis_tx_last,
  input  logic [TX_TIMESTAMP_BITS-2:0]                                      fe_time,
  output logic [TX_RAM_ADDR_WIDTH-RAM_CHECK_BIT:0]                          out_rd_addr,
  output logic [TX_TIMESTAMP_BITS-1:0]                                      out_rd_time,
  output logic [15:0]                                                       stat_late,
  output logic [15:0]                                                       stat_underrun
);
  localparam int AW  = TX_RAM_ADDR_WIDTH - DATA_BITS;
  localparam int PW  = AW + 1;
  localparam int DW  = 8 << DATA_BITS;
  localparam int TS  = TX_TIMESTAMP_BITS;
  localparam int DSW = TS + TX_SAMPLES_WIDTH + AW;

  typedef enum logic [1:0] {IDLE, CHECK, WAIT, PLAY} state_t;

  state_t          state, state_nxt;
  logic            rdy_en;
  logic            nots_q;
  logic [TS-2:0]   ts_q;
  logic [AW-1:0]   wm1_q;
  logic [PW-1:0]   rd_ptr, ret_ptr;
  logic [AW:0]     iss_cnt, ret_cnt;
  logic            rd_vld_q;
  logic [DW-1:0]   skid_mem [2];
  logic            skid_wr, skid_rd;
  logic [1:0]      skid_cnt;

  logic            accept, late, issue, pop, push, spop, last_word;
  logic [TS-1:0]   diff;
  logic [PW-1:0]   out_cnt;
  logic [AW:0]     burst_len;
  logic            descr_unused;

  // Sample count travels with the descriptor but has no role in playback.
  assign descr_unused = ^s_descr_data[AW +: TX_SAMPLES_WIDTH];

  assign s_descr_ready = rdy_en && (state == IDLE);
  assign s_descr_busy  = (state != IDLE) || s_descr_valid;
  assign accept        = s_descr_valid && s_descr_ready;

  assign diff      = {1'b0, fe_time} - {1'b0, ts_q};
  assign late      = (state == CHECK) && !nots_q && (diff != '0) && !diff[TS-1];
  assign burst_len = {1'b0, wm1_q} + 1'b1;
  assign out_cnt   = rd_ptr - ret_ptr;

  // Skid head first; an empty skid forwards the RAM return directly.
  assign m_axis_tx_valid = (state == PLAY) && ((skid_cnt != 2'd0) || rd_vld_q);
  assign m_axis_tx_data  = (skid_cnt != 2'd0) ? skid_mem[skid_rd] : mem_rd_data;
  assign last_word       = (ret_cnt == {1'b0, wm1_q});
  assign m_axis_tx_last  = m_axis_tx_valid && last_word;
  assign pop             = m_axis_tx_valid && m_axis_tx_ready;

  // Counting this cycle's retire keeps full rate while capping in-flight words at 2.
  assign issue = (state == PLAY) && (iss_cnt != burst_len) &&
                 ((out_cnt - PW'(pop)) < PW'(2));
  assign mem_rd_en   = issue;
  assign mem_rd_addr = rd_ptr[AW-1:0];

  assign spop = pop && (skid_cnt != 2'd0);
  assign push = rd_vld_q && !((skid_cnt == 2'd0) && pop);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = CHECK;
      CHECK: begin
        if (nots_q || diff == '0) state_nxt = PLAY;
        else if (diff[TS-1])      state_nxt = WAIT;
        else                      state_nxt = IDLE;
      end
      WAIT:  if (fe_time == ts_q) state_nxt = PLAY;
      PLAY:  if (pop && last_word) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rdy_en        <= 1'b0;
      nots_q        <= 1'b0;
      ts_q          <= '0;
      wm1_q         <= '0;
      rd_ptr        <= '0;
      ret_ptr       <= '0;
      iss_cnt       <= '0;
      ret_cnt       <= '0;
      rd_vld_q      <= 1'b0;
      skid_wr       <= 1'b0;
      skid_rd       <= 1'b0;
      skid_cnt      <= 2'd0;
      stat_late     <= '0;
      stat_underrun <= '0;
      out_rd_addr   <= '0;
      out_rd_time   <= '0;
    end else begin
      state       <= state_nxt;
      rdy_en      <= 1'b1;
      rd_vld_q    <= issue;
      out_rd_addr <= ret_ptr[PW-1:RAM_CHECK_BIT-DATA_BITS];
      out_rd_time <= {1'b0, fe_time};
      if (accept) begin
        nots_q  <= s_descr_data[DSW-1];
        ts_q    <= s_descr_data[DSW-2 -: TS-1];
        wm1_q   <= s_descr_data[AW-1:0];
        iss_cnt <= '0;
        ret_cnt <= '0;
      end else begin
        if (issue) iss_cnt <= iss_cnt + 1'b1;
        if (pop)   ret_cnt <= ret_cnt + 1'b1;
      end
      // A late burst is retired wholesale so the deframer sees its space freed.
      if (late) begin
        rd_ptr    <= rd_ptr + burst_len;
        ret_ptr   <= ret_ptr + burst_len;
        stat_late <= stat_late + 1'b1;
      end else begin
        if (issue) rd_ptr  <= rd_ptr + 1'b1;
        if (pop)   ret_ptr <= ret_ptr + 1'b1;
      end
      if (push) skid_wr <= ~skid_wr;
      if (spop) skid_rd <= ~skid_rd;
      skid_cnt <= skid_cnt + 2'(push) - 2'(spop);
      if ((state == PLAY) && m_axis_tx_ready && !m_axis_tx_valid && (stat_underrun != 16'hFFFF))
        stat_underrun <= stat_underrun + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) skid_mem[skid_wr] <= mem_rd_data;
  end

endmodule

// File: tb/tb_usbeps_tx_burst_player.sv
// Bench for usbeps_tx_burst_player: RAM model, expected-word scoreboard, directed burst scenarios.
module tb_usbeps_tx_burst_player;
  localparam int DB  = 3;
  localparam int TS  = 49;
  localparam int RAW = 8;
  localparam int SW  = 7;
  localparam int RCB = 4;
  localparam int AW  = RAW - DB;
  localparam int PW  = AW + 1;
  localparam int DW  = 8 << DB;
  localparam int OW  = AW + DB - RCB + 1;
  localparam int DSW = TS + SW + AW;

  logic           clk, rst_n;
  logic [DSW-1:0] s_descr_data;
  logic           s_descr_valid, s_descr_ready, s_descr_busy;
  logic           mem_rd_en;
  logic [AW-1:0]  mem_rd_addr;
  logic [DW-1:0]  mem_rd_data;
  logic           m_axis_tx_valid, m_axis_tx_ready, m_axis_tx_last;
  logic [DW-1:0]  m_axis_tx_data;
  logic [TS-2:0]  fe_time;
  logic [OW-1:0]  out_rd_addr;
  logic [TS-1:0]  out_rd_time;
  logic [15:0]    stat_late, stat_underrun;

  usbeps_tx_burst_player #(
    .DATA_BITS(DB), .TX_TIMESTAMP_BITS(TS), .TX_RAM_ADDR_WIDTH(RAW),
    .TX_SAMPLES_WIDTH(SW), .RAM_CHECK_BIT(RCB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_descr_data(s_descr_data), .s_descr_valid(s_descr_valid),
    .s_descr_ready(s_descr_ready), .s_descr_busy(s_descr_busy),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .m_axis_tx_valid(m_axis_tx_valid), .m_axis_tx_ready(m_axis_tx_ready),
    .m_axis_tx_data(m_axis_tx_data), .m_axis_tx_last(m_axis_tx_last),
    .fe_time(fe_time), .out_rd_addr(out_rd_addr), .out_rd_time(out_rd_time),
    .stat_late(stat_late), .stat_underrun(stat_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

  typedef struct packed { logic [DW-1:0] d; logic l; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rdy_mode = 0;
  logic [PW-1:0] mptr = '0;
  int mlate = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    fe_time = fe_time + 1'b1;
    cyc++;
    case (rdy_mode)
      0:       m_axis_tx_ready = 1'b1;
      1:       m_axis_tx_ready = 1'($urandom_range(0, 1));
      default: m_axis_tx_ready = 1'b0;
    endcase
  endtask

  task automatic push_burst(input int wm1);
    for (int i = 0; i <= wm1; i++) begin
      logic [AW-1:0] a;
      exp_t e;
      a = AW'(mptr + PW'(i));
      e.d = ram[a];
      e.l = (i == wm1);
      exp_q.push_back(e);
    end
    mptr = mptr + PW'(wm1 + 1);
  endtask

  task automatic send_descr(input logic nots, input logic [TS-2:0] ts, input int wm1);
    int guard;
    s_descr_data  = {nots, ts, SW'($urandom), AW'(wm1)};
    s_descr_valid = 1'b1;
    guard = 0;
    while (!s_descr_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) check_val("descr_accept_timeout", 0, 1);
    tick();
    s_descr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while ((s_descr_busy || exp_q.size() != 0) && guard < 2000) begin
      tick();
      guard++;
    end
    if (guard >= 2000) check_val(tag, 0, 1);
    tick();
    tick();
  endtask

  // Watches valid after a descriptor: first/last valid cycle, count, and when fe_time hits tgt.
  task automatic measure(input logic [TS-2:0] tgt, output int first, output int last,
                         output int nvld, output int match);
    int guard;
    first = -1; last = -1; nvld = 0; match = -1; guard = 0;
    while ((exp_q.size() != 0) && guard < 2000) begin
      tick();
      guard++;
      if (fe_time == tgt && match < 0) match = cyc;
      if (m_axis_tx_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        nvld++;
      end
    end
    if (guard >= 2000) check_val("measure_timeout", 0, 1);
  endtask

  logic          stalled = 1'b0;
  logic [DW-1:0] held;
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      if (m_axis_tx_valid && m_axis_tx_ready) begin
        if (exp_q.size() == 0) check_val("unexpected_word", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_val("tx_data", m_axis_tx_data, e.d);
          check_val("tx_last", m_axis_tx_last, e.l);
        end
      end
      if (stalled) begin
        check_val("stall_valid", m_axis_tx_valid, 1);
        check_val("stall_data", m_axis_tx_data, held);
      end
      stalled = m_axis_tx_valid && !m_axis_tx_ready;
      held    = m_axis_tx_data;
    end
  end

  initial begin
    int f, l, n, m, n6;
    logic [15:0] ur0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = {$urandom, $urandom};
    rst_n = 1'b0;
    s_descr_valid = 1'b0;
    s_descr_data = '0;
    m_axis_tx_ready = 1'b1;
    fe_time = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_descr_ready", s_descr_ready, 0);
    check_val("rst_tx_valid", m_axis_tx_valid, 0);
    check_val("rst_mem_rd_en", mem_rd_en, 0);
    check_val("rst_rd_addr", out_rd_addr, 0);
    check_val("rst_stat_late", stat_late, 0);
    check_val("rst_underrun", stat_underrun, 0);
    rst_n = 1'b1;
    tick();
    check_val("post_rst_ready", s_descr_ready, 1);
    tick();
    check_val("rd_time", out_rd_time, {1'b0, fe_time - 1'b1});

    // 1: no-TS 4-word burst, back to back
    rdy_mode = 0;
    push_burst(3);
    send_descr(1'b1, '0, 3);
    measure('1, f, l, n, m);
    check_val("t1_count", n, 4);
    check_val("t1_b2b", l - f, 3);
    wait_idle("t1_idle_timeout");
    check_val("t1_rd_addr", out_rd_addr, 2);

    // 2: future timestamp waits for exact match
    fe_time = 48'd989;
    push_burst(2);
    send_descr(1'b0, 48'd1000, 2);
    measure(48'd1000, f, l, n, m);
    check_val("t2_latency_ok", (m >= 0 && f - m >= 1 && f - m <= 2), 1);
    wait_idle("t2_idle_timeout");
    check_val("t2_stat_late", stat_late, 0);

    // 3: late burst skipped, next burst plays after it
    fe_time = 48'd599;
    send_descr(1'b0, 48'd500, 5);
    mptr = mptr + PW'(6);
    mlate++;
    wait_idle("t3_idle_timeout");
    check_val("t3_stat_late", stat_late, mlate);
    check_val("t3_rd_addr", out_rd_addr, mptr[PW-1:RCB-DB]);
    push_burst(2);
    send_descr(1'b1, '0, 2);
    wait_idle("t3b_idle_timeout");
    check_val("t3b_rd_addr", out_rd_addr, mptr[PW-1:RCB-DB]);

    // 4: random backpressure over 16 words
    rdy_mode = 1;
    push_burst(15);
    send_descr(1'b1, '0, 15);
    wait_idle("t4_idle_timeout");
    rdy_mode = 0;
    check_val("t4_q_empty", exp_q.size(), 0);
    check_val("t4_rd_addr", out_rd_addr, mptr[PW-1:RCB-DB]);

    // 5: held-off ready is not underrun; ready high before data is
    rdy_mode = 2;
    tick();
    ur0 = stat_underrun;
    push_burst(7);
    send_descr(1'b1, '0, 7);
    repeat (12) tick();
    check_val("t5_valid_held", m_axis_tx_valid, 1);
    rdy_mode = 0;
    wait_idle("t5_idle_timeout");
    check_val("t5_underrun_hold", stat_underrun, ur0);
    ur0 = stat_underrun;
    push_burst(3);
    send_descr(1'b1, '0, 3);
    wait_idle("t5b_idle_timeout");
    check_val("t5_underrun_inc", (stat_underrun > ur0), 1);

    // 6: skip late bursts up to 2^(AW+1)-2, then play across the wrap
    fe_time = 48'd100000;
    while (mptr != PW'((1 << PW) - 2)) begin
      n6 = int'(PW'(((1 << PW) - 2) - int'(mptr)));
      if (n6 > (1 << AW)) n6 = 1 << AW;
      send_descr(1'b0, '0, n6 - 1);
      mptr = mptr + PW'(n6);
      mlate++;
      wait_idle("t6_skip_timeout");
    end
    check_val("t6_pre_rd_addr", out_rd_addr, ((1 << PW) - 2) >> (RCB - DB));
    check_val("t6_stat_late", stat_late, mlate);
    push_burst(3);
    send_descr(1'b1, '0, 3);
    wait_idle("t6_idle_timeout");
    check_val("t6_post_rd_addr", out_rd_addr, 1);
    check_val("t6_wrap_bit", out_rd_addr[OW-1], 0);
    tick();
    check_val("rd_time_end", out_rd_time, {1'b0, fe_time - 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
